// File: rtl/lpc_pkg.sv
// Shared types and protocol constants for the passive LPC host-cycle decoder.
package lpc_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [3:0] {
    IDLE, START, CTDIR, ADDR, WDATA, TAR1, SYNC, RDATA, TAR2
  } lpc_state_e;

  localparam logic [1:0] CT_IO  = 2'b00;
  localparam logic [1:0] CT_MEM = 2'b01;

  localparam logic [NIB_W-1:0] SYNC_READY   = 4'b0000;
  localparam logic [NIB_W-1:0] SYNC_SHORT   = 4'b0101;
  localparam logic [NIB_W-1:0] SYNC_LONG    = 4'b0110;
  localparam logic [NIB_W-1:0] SYNC_ERR     = 4'b1010;
  localparam logic [NIB_W-1:0] START_TARGET = 4'b0000;
  localparam logic [NIB_W-1:0] ABORT        = 4'b1111;

  // One completed cycle as handed to the capture path.
  typedef struct packed {
    logic [NIB_W-1:0]  cyctype_dir;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              sync_err;
  } lpc_record_t;

  // Address length in nibbles for a given cycle type.
  function automatic logic [3:0] addr_nibbles(input logic [1:0] ct);
    return (ct == CT_MEM) ? 4'd8 : 4'd4;
  endfunction

endpackage

// File: rtl/lpc_nibble_shift.sv
// Nibble accumulator with a per-phase length; done_c flags the final nibble as it is taken.
module lpc_nibble_shift
  import lpc_pkg::*;
#(
  parameter int unsigned NIBBLES   = 8,
  parameter bit          MSN_FIRST = 1'b1,
  localparam int unsigned W        = NIB_W * NIBBLES,
  localparam int unsigned CW       = $clog2(NIBBLES + 1)
) (
  input  logic             lpc_clock,
  input  logic             lpc_reset,
  input  logic             clear,
  input  logic             shift,
  input  logic [CW-1:0]    count,
  input  logic [NIB_W-1:0] nibble,
  output logic [W-1:0]     value,
  output logic             done_c
);

  logic [CW-1:0] cnt_q;

  assign done_c = shift && (cnt_q == count - CW'(1));

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      cnt_q <= '0;
      value <= '0;
    end else if (clear) begin
      cnt_q <= '0;
      value <= '0;
    end else if (shift) begin
      value <= MSN_FIRST ? {value[W-NIB_W-1:0], nibble} : {nibble, value[W-1:NIB_W]};
      cnt_q <= done_c ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/lpc_cycle_decoder.sv
// Passive LPC I/O + memory cycle decoder; one record per completed cycle, drop pulse on abandon.
module lpc_cycle_decoder
  import lpc_pkg::*;
#(
  parameter bit          ENABLE_IO    = 1'b1,
  parameter bit          ENABLE_MEM   = 1'b1,
  parameter int unsigned SYNC_TIMEOUT = 64
) (
  input  logic              lpc_clock,
  input  logic              lpc_reset,
  input  logic [NIB_W-1:0]  lpc_ad,
  input  logic              lpc_frame,
  output logic [NIB_W-1:0]  out_cyctype_dir,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sync_err,
  output logic              out_valid,
  output logic              out_drop
);

  lpc_state_e        state_q, state_d;
  logic              phase_q, phase_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic [NIB_W-1:0]  ctdir_q, ctdir_d;
  logic              serr_q, serr_d;
  logic              valid_d, drop_d;
  logic              addr_clr, addr_shift, data_shift;
  logic              addr_done_c, data_done_c, ct_ok;
  logic [ADDR_W-1:0] addr_val;
  logic [DATA_W-1:0] data_val;
  lpc_record_t       rec_q;

  lpc_nibble_shift #(.NIBBLES(8), .MSN_FIRST(1'b1)) u_addr_shift (
    .lpc_clock (lpc_clock),
    .lpc_reset (lpc_reset),
    .clear     (addr_clr),
    .shift     (addr_shift),
    .count     (addr_nibbles(ctdir_q[3:2])),
    .nibble    (lpc_ad),
    .value     (addr_val),
    .done_c    (addr_done_c)
  );

  lpc_nibble_shift #(.NIBBLES(2), .MSN_FIRST(1'b0)) u_data_shift (
    .lpc_clock (lpc_clock),
    .lpc_reset (lpc_reset),
    .clear     (addr_clr),
    .shift     (data_shift),
    .count     (2'd2),
    .nibble    (lpc_ad),
    .value     (data_val),
    .done_c    (data_done_c)
  );

  assign wait_inc = wait_q + WAIT_W'(1);
  assign ct_ok    = ((lpc_ad[3:2] == CT_IO)  && ENABLE_IO) ||
                    ((lpc_ad[3:2] == CT_MEM) && ENABLE_MEM);

  // Next-state and control; LFRAME# low in any active state restarts or aborts.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    wait_d     = wait_q;
    ctdir_d    = ctdir_q;
    serr_d     = serr_q;
    valid_d    = 1'b0;
    drop_d     = 1'b0;
    addr_clr   = 1'b0;
    addr_shift = 1'b0;
    data_shift = 1'b0;
    if (state_q != IDLE && !lpc_frame) begin
      drop_d  = (state_q != START);
      state_d = (lpc_ad == START_TARGET) ? START : IDLE;
    end else begin
      case (state_q)
        IDLE: if (!lpc_frame && lpc_ad == START_TARGET) state_d = START;
        START: begin
          ctdir_d = lpc_ad;
          if (ct_ok) begin
            state_d  = ADDR;
            addr_clr = 1'b1;
          end else begin
            state_d = IDLE;
            drop_d  = 1'b1;
          end
        end
        ADDR: begin
          addr_shift = 1'b1;
          phase_d    = 1'b0;
          if (addr_done_c) state_d = ctdir_q[1] ? WDATA : TAR1;
        end
        WDATA: begin
          data_shift = 1'b1;
          phase_d    = 1'b0;
          if (data_done_c) state_d = TAR1;
        end
        TAR1: begin
          phase_d = ~phase_q;
          wait_d  = '0;
          if (phase_q) state_d = SYNC;
        end
        SYNC: begin
          phase_d = 1'b0;
          case (lpc_ad)
            SYNC_READY, SYNC_ERR: begin
              serr_d  = (lpc_ad == SYNC_ERR);
              state_d = ctdir_q[1] ? TAR2 : RDATA;
            end
            SYNC_SHORT, SYNC_LONG: begin
              wait_d = wait_inc;
              if (wait_inc == WAIT_W'(SYNC_TIMEOUT)) begin
                state_d = IDLE;
                drop_d  = 1'b1;
              end
            end
            default: begin
              state_d = IDLE;
              drop_d  = 1'b1;
            end
          endcase
        end
        RDATA: begin
          data_shift = 1'b1;
          phase_d    = 1'b0;
          if (data_done_c) state_d = TAR2;
        end
        TAR2: begin
          phase_d = ~phase_q;
          if (phase_q) begin
            valid_d = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      wait_q    <= '0;
      ctdir_q   <= '0;
      serr_q    <= 1'b0;
      rec_q     <= '0;
      out_valid <= 1'b0;
      out_drop  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      wait_q    <= wait_d;
      ctdir_q   <= ctdir_d;
      serr_q    <= serr_d;
      out_valid <= valid_d;
      out_drop  <= drop_d;
      if (valid_d) rec_q <= '{ctdir_q, addr_val, data_val, serr_q};
    end
  end

  assign out_cyctype_dir = rec_q.cyctype_dir;
  assign out_addr        = rec_q.addr;
  assign out_data        = rec_q.data;
  assign out_sync_err    = rec_q.sync_err;

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// Scoreboard bench for lpc_cycle_decoder: I/O and memory cycles, waits, sync error, abort, timeout, reset.
module tb_lpc_cycle_decoder;
  import lpc_pkg::*;

  localparam int TB_TIMEOUT = 64;

  logic        lpc_clock = 1'b0;
  logic        lpc_reset = 1'b0;
  logic        lpc_frame = 1'b1;
  logic [3:0]  lpc_ad    = 4'hF;
  logic [3:0]  out_cyctype_dir, out_cyctype_dir2;
  logic [31:0] out_addr, out_addr2;
  logic [7:0]  out_data, out_data2;
  logic        out_sync_err, out_sync_err2;
  logic        out_valid, out_valid2, out_drop, out_drop2;

  lpc_cycle_decoder #(.ENABLE_IO(1'b1), .ENABLE_MEM(1'b1), .SYNC_TIMEOUT(TB_TIMEOUT)) dut (
    .lpc_clock(lpc_clock), .lpc_reset(lpc_reset), .lpc_ad(lpc_ad), .lpc_frame(lpc_frame),
    .out_cyctype_dir(out_cyctype_dir), .out_addr(out_addr), .out_data(out_data),
    .out_sync_err(out_sync_err), .out_valid(out_valid), .out_drop(out_drop));

  lpc_cycle_decoder #(.ENABLE_IO(1'b1), .ENABLE_MEM(1'b0), .SYNC_TIMEOUT(TB_TIMEOUT)) dut_nomem (
    .lpc_clock(lpc_clock), .lpc_reset(lpc_reset), .lpc_ad(lpc_ad), .lpc_frame(lpc_frame),
    .out_cyctype_dir(out_cyctype_dir2), .out_addr(out_addr2), .out_data(out_data2),
    .out_sync_err(out_sync_err2), .out_valid(out_valid2), .out_drop(out_drop2));

  always #15 lpc_clock = ~lpc_clock;

  typedef struct {
    bit         is_drop;
    int         at;
    logic [3:0] ctdir;
    logic [31:0] addr;
    logic [7:0] data;
    logic       serr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int cyc = 0;
  int n_total = 0;
  int n_pass = 0;
  int v2 = 0, d2 = 0;
  logic [3:0]  last_ctdir = '0;
  logic [31:0] last_addr  = '0;
  logic [7:0]  last_data  = '0;
  logic        last_serr  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(posedge lpc_clock) cyc <= cyc + 1;

  always @(negedge lpc_clock) begin
    if (out_valid2) v2++;
    if (out_drop2) d2++;
  end

  // Pops one expectation per pulse; an expectation whose cycle passes unseen is a miss.
  always @(negedge lpc_clock) begin
    if (out_valid || out_drop) begin
      check("valid_drop_excl", 32'(out_valid & out_drop), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({out_valid, out_drop}), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("kind_drop", 32'(out_drop), 32'(mon_e.is_drop));
        check("pulse_cycle", 32'(cyc), 32'(mon_e.at));
        check("cyctype_dir", 32'(out_cyctype_dir), 32'(mon_e.ctdir));
        check("addr", out_addr, mon_e.addr);
        check("data", 32'(out_data), 32'(mon_e.data));
        check("sync_err", 32'(out_sync_err), 32'(mon_e.serr));
      end
    end else if (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      check("missing_pulse", 32'({out_valid, out_drop}), mon_e.is_drop ? 32'd1 : 32'd2);
    end
  end

  task automatic drive(input logic frame, input logic [3:0] ad);
    @(negedge lpc_clock);
    lpc_frame = frame;
    lpc_ad    = ad;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 4'hF);
  endtask

  // Called right after a drive; the pulse appears two edges later.
  task automatic push_valid(input logic [3:0] ctdir, input logic [31:0] addr,
                            input logic [7:0] data, input logic serr);
    exp_t e;
    e.is_drop = 1'b0; e.at = cyc + 2;
    e.ctdir = ctdir; e.addr = addr; e.data = data; e.serr = serr;
    sb.push_back(e);
    last_ctdir = ctdir; last_addr = addr; last_data = data; last_serr = serr;
  endtask

  task automatic push_drop();
    exp_t e;
    e.is_drop = 1'b1; e.at = cyc + 2;
    e.ctdir = last_ctdir; e.addr = last_addr; e.data = last_data; e.serr = last_serr;
    sb.push_back(e);
  endtask

  task automatic run_cycle(input logic [3:0] ctdir, input logic [31:0] addr, input logic [7:0] data,
                           input int waits, input logic [3:0] wcode, input logic [3:0] fin);
    bit is_mem;
    bit wr;
    int n;
    is_mem = (ctdir[3:2] == CT_MEM);
    wr     = ctdir[1];
    n      = is_mem ? 8 : 4;
    drive(1'b0, START_TARGET);
    drive(1'b1, ctdir);
    for (int i = n - 1; i >= 0; i--) drive(1'b1, addr[4*i +: 4]);
    if (wr) begin
      drive(1'b1, data[3:0]);
      drive(1'b1, data[7:4]);
    end
    drive(1'b1, 4'hF);
    drive(1'b1, 4'hF);
    for (int w = 0; w < waits; w++) begin
      if (w == TB_TIMEOUT - 1) begin
        push_drop();
        drive(1'b1, wcode);
        return;
      end
      drive(1'b1, wcode);
    end
    drive(1'b1, fin);
    if (!wr) begin
      drive(1'b1, data[3:0]);
      drive(1'b1, data[7:4]);
    end
    drive(1'b1, 4'hF);
    push_valid(ctdir, is_mem ? addr : {16'h0, addr[15:0]}, data, fin == SYNC_ERR);
    drive(1'b1, 4'hF);
  endtask

  initial begin
    int d2_0, v2_0;
    repeat (3) @(negedge lpc_clock);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_addr", out_addr, 32'd0);
    lpc_reset = 1'b1;
    idle(2);

    run_cycle(4'b0010, 32'h0000_0080, 8'h5A, 0, SYNC_SHORT, SYNC_READY);
    idle(2);

    d2_0 = d2; v2_0 = v2;
    run_cycle(4'b0100, 32'hFFFF_FFF0, 8'h3C, 3, SYNC_LONG, SYNC_READY);
    idle(3);
    check("nomem_drop_count", 32'(d2 - d2_0), 32'd1);
    check("nomem_valid_count", 32'(v2 - v2_0), 32'd0);

    run_cycle(4'b0000, 32'h0000_03F8, 8'hA7, 0, SYNC_SHORT, SYNC_ERR);
    run_cycle(4'b0010, 32'h0000_002E, 8'h11, 1, SYNC_SHORT, SYNC_READY);
    idle(2);

    // Abort in place of the second address nibble.
    drive(1'b0, START_TARGET);
    drive(1'b1, 4'b0010);
    drive(1'b1, 4'h1);
    push_drop();
    drive(1'b0, ABORT);
    idle(3);
    check("abort_retain_addr", out_addr, 32'h0000_002E);
    check("abort_retain_data", 32'(out_data), 32'h11);

    run_cycle(4'b0000, 32'h0000_0060, 8'h00, TB_TIMEOUT, SYNC_SHORT, SYNC_READY);
    idle(3);
    run_cycle(4'b0000, 32'h0000_0061, 8'h42, 0, SYNC_SHORT, SYNC_READY);
    idle(2);

    // Reset in the middle of SYNC wait states.
    drive(1'b0, START_TARGET);
    drive(1'b1, 4'b0000);
    for (int i = 0; i < 4; i++) drive(1'b1, 4'h7);
    drive(1'b1, 4'hF);
    drive(1'b1, 4'hF);
    for (int i = 0; i < 3; i++) drive(1'b1, SYNC_LONG);
    #5 lpc_reset = 1'b0;
    #1;
    check("rst_addr", out_addr, 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ctdir", 32'(out_cyctype_dir), 32'd0);
    check("rst_serr", 32'(out_sync_err), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_drop", 32'(out_drop), 32'd0);
    last_ctdir = '0; last_addr = '0; last_data = '0; last_serr = 1'b0;
    lpc_frame = 1'b1;
    lpc_ad    = 4'hF;
    @(negedge lpc_clock);
    lpc_reset = 1'b1;
    idle(2);
    run_cycle(4'b0010, 32'h0000_0080, 8'h5A, 0, SYNC_SHORT, SYNC_READY);
    idle(4);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lpc_cycle_decoder.md
Name: lpc_cycle_decoder

Overview:
- Passive LPC host-cycle decoder, the parametrised successor to the team's single-mode I/O sniffer.
- Decodes I/O and memory cycles, reads and writes, with a 16- or 32-bit address.
- Handles full TAR/SYNC sequencing including wait states, sync-error and abort.
- Emits one record per completed cycle to the downstream capture FIFO/UART path.

Parameters:
- ENABLE_IO, 1, decode I/O cycles (CT 00); 0 = ignore them.
- ENABLE_MEM, 1, decode memory cycles (CT 01); 0 = ignore them.
- SYNC_TIMEOUT, 64, maximum consecutive wait-SYNC clocks before the cycle is dropped; 8-bit counter.

Ports:
- lpc_clock  in  1  LPC 33 MHz clock; all sampling on the rising edge.
- lpc_reset  in  1  LRESET#, asynchronous, active-low.
- lpc_ad  in  4  LAD[3:0].
- lpc_frame  in  1  LFRAME#, active-low.
- out_cyctype_dir  out  4  CT/DIR nibble as sampled (bit1 = write).
- out_addr  out  32  cycle address; bits 31:16 are 0 for I/O.
- out_data  out  8  data byte.
- out_sync_err  out  1  the cycle ended with SYNC 1010.
- out_valid  out  1  one-clock pulse; record fields stable from the pulse until the next pulse.
- out_drop  out  1  one-clock pulse when a started cycle is abandoned (abort, timeout, illegal SYNC, disabled/unsupported CT).

Behaviour:
- Reset (async, lpc_reset low): state IDLE; every output 0; counters 0. Reset mid-cycle discards the cycle with no out_drop.
- LAD nibble order: address MS nibble first; data LS nibble first (data[3:0], then data[7:4]).
- States: IDLE, START, CTDIR, ADDR, WDATA, TAR1, SYNC, RDATA, TAR2.
- IDLE: lpc_frame low and lpc_ad==0000 -> START.
- START: lpc_frame still low and ad==0000 -> stay; lpc_frame still low and ad!=0000 -> IDLE; lpc_frame high -> the sampled nibble is CT/DIR.
  - CT 00 with ENABLE_IO, or CT 01 with ENABLE_MEM -> ADDR, counter=0, nibble count 4 (IO) or 8 (MEM).
  - Otherwise -> IDLE and pulse out_drop.
- ADDR: shift 1 nibble/clock. After the last nibble: write -> WDATA, read -> TAR1.
- WDATA: 2 clocks -> TAR1.
- TAR1: 2 clocks, LAD ignored -> SYNC; wait counter cleared.
- SYNC: per clock.
  - 0000 -> ready, sync_err=0.
  - 1010 -> ready, sync_err=1.
  - 0101 or 0110 -> wait; counter++. Reaching SYNC_TIMEOUT -> IDLE + out_drop.
  - Any other value -> IDLE + out_drop.
  - On ready: read -> RDATA, write -> TAR2.
- RDATA: 2 clocks -> TAR2.
- TAR2: 2 clocks. On the second clock, register outputs and pulse out_valid on the next edge; state -> IDLE in the same edge.
- Abort/restart: in any non-IDLE state, lpc_frame low overrides everything.
  - Cycle in progress is discarded and out_drop pulses once (except from START).
  - ad==0000 -> START; otherwise -> IDLE. LFRAME# low + 1111 is an abort.
- Back-to-back: a new START in the clock right after TAR2 is accepted. out_valid for the previous cycle still pulses.
- Output registers update only at out_valid. A dropped cycle never alters out_addr/out_data/out_cyctype_dir.
- out_valid and out_drop are never high together.

Decomposition:
- Package lpc_pkg:
  - state enum.
  - CT constants: CT_IO=2'b00, CT_MEM=2'b01.
  - SYNC codes: SYNC_READY=0000, SYNC_SHORT=0101, SYNC_LONG=0110, SYNC_ERR=1010.
  - START_TARGET=0000, ABORT=1111.
- Sub-module lpc_nibble_shift: parametrised nibble accumulator with counter and done flag, shared by the address and data phases. The FSM stays in the top module.

Test Plan:
- I/O write: START, CT 0010, addr 0x0080, data 0x5A (A,5), TAR, SYNC 0000, TAR -> one out_valid; cyctype 0010, addr 0x00000080, data 0x5A, sync_err 0.
- Memory read: CT 0100, addr 0xFFFFFFF0, TAR, 3x SYNC 0110 then 0000, data 0x3C -> out_valid; addr 0xFFFFFFF0, data 0x3C.
- I/O read with SYNC 1010 -> out_valid with out_sync_err=1, data captured.
- Abort: LFRAME low + 1111 during ADDR nibble 2 -> out_drop one pulse; no out_valid; outputs retain the previous record.
- Timeout: SYNC 0101 held 64 clocks -> out_drop on clock 64, state IDLE. With ENABLE_MEM=0, a memory cycle -> out_drop at CTDIR and no valid.
- Async reset asserted mid-SYNC -> all outputs 0 immediately. The next full I/O write decodes correctly.
